// File: rtl/restador_8bits_if.sv
`default_nettype none
// ============================================================================
// restador_8bits_if : command/status bundle of the 8-bit registered subtractor
// Rev 1.0
// ============================================================================
interface restador_8bits_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] step;
    logic             sat_mode;
    logic             clear_halt;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             zero;
    logic             busy;
    logic             halted;

    modport master (
        output enable, load, load_val, step, sat_mode, clear_halt,
        input  d, bout, zero, busy, halted
    );

    modport slave (
        input  enable, load, load_val, step, sat_mode, clear_halt,
        output d, bout, zero, busy, halted
    );
endinterface
`default_nettype wire

// File: rtl/restador_8bits.sv
`default_nettype none
// ============================================================================
// restador_8bits : registered down-counter/subtractor, wrap or saturating halt
// Rev 1.0
// ============================================================================
module restador_8bits #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = 8'hFF
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    restador_8bits_if.slave    bus
);
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_HALT = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_zero;

    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_d_nxt;
    logic             w_bout_nxt;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;

    // Extra MSB of the widened difference is the borrow (step > d).
    assign w_diff   = {1'b0, r_d} - {1'b0, bus.step};
    assign w_borrow = w_diff[WIDTH];

    always_comb begin
        w_state_nxt = r_state;
        w_d_nxt     = r_d;
        w_bout_nxt  = 1'b0;
        if (bus.load) begin
            w_d_nxt     = bus.load_val;
            w_state_nxt = c_IDLE;
        end else if (r_state == c_HALT) begin
            if (bus.clear_halt) begin
                w_state_nxt = c_IDLE;
            end
        end else if (bus.enable) begin
            w_bout_nxt = w_borrow;
            if (w_borrow && bus.sat_mode) begin
                w_d_nxt     = '0;
                w_state_nxt = c_HALT;
            end else begin
                w_d_nxt     = w_diff[WIDTH-1:0];
                w_state_nxt = c_RUN;
            end
        end else begin
            w_state_nxt = c_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_d     <= RESET_VALUE;
            r_bout  <= 1'b0;
            r_zero  <= (RESET_VALUE == '0);
        end else begin
            r_state <= w_state_nxt;
            r_d     <= w_d_nxt;
            r_bout  <= w_bout_nxt;
            r_zero  <= (w_d_nxt == '0);
        end
    end

    assign bus.d      = r_d;
    assign bus.bout   = r_bout;
    assign bus.zero   = r_zero;
    assign bus.busy   = (r_state == c_RUN);
    assign bus.halted = (r_state == c_HALT);
endmodule
`default_nettype wire

// File: tb/tb_restador_8bits.sv
`default_nettype none
// ============================================================================
// tb_restador_8bits : directed plus randomized checks against a behavioural model
// Rev 1.0
// ============================================================================
module tb_restador_8bits;
    typedef enum int {M_IDLE, M_RUN, M_HALT} mstate_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    int      m_d;
    int      m_bout;
    mstate_t m_st;

    restador_8bits_if #(.WIDTH(8)) bus ();

    restador_8bits #(.WIDTH(8), .RESET_VALUE(8'hFF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".d"},      32'(bus.d),      32'(m_d));
        check({tag, ".bout"},   32'(bus.bout),   32'(m_bout));
        check({tag, ".zero"},   32'(bus.zero),   32'(m_d == 0));
        check({tag, ".busy"},   32'(bus.busy),   32'(m_st == M_RUN));
        check({tag, ".halted"}, 32'(bus.halted), 32'(m_st == M_HALT));
    endtask

    task automatic model_reset();
        m_d    = 255;
        m_bout = 0;
        m_st   = M_IDLE;
    endtask

    // Reference behaviour for one clock edge, from the currently driven inputs.
    task automatic model_edge();
        int s;
        s      = int'(bus.step);
        m_bout = 0;
        if (bus.load) begin
            m_d  = int'(bus.load_val);
            m_st = M_IDLE;
        end else if (m_st == M_HALT) begin
            if (bus.clear_halt) m_st = M_IDLE;
        end else if (bus.enable) begin
            if (s > m_d) begin
                m_bout = 1;
                if (bus.sat_mode) begin
                    m_d  = 0;
                    m_st = M_HALT;
                end else begin
                    m_d  = (m_d - s + 256) % 256;
                    m_st = M_RUN;
                end
            end else begin
                m_d  = m_d - s;
                m_st = M_RUN;
            end
        end else begin
            m_st = M_IDLE;
        end
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic en, input logic ld, input logic [7:0] lv,
                         input logic [7:0] st, input logic sm, input logic ch);
        bus.enable     = en;
        bus.load       = ld;
        bus.load_val   = lv;
        bus.step       = st;
        bus.sat_mode   = sm;
        bus.clear_halt = ch;
    endtask

    // Asserted mid-cycle; outputs must change without any clock edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        model_reset();

        // Reset asserted between edges
        @(posedge clk);
        #3;
        do_reset("t1");

        // Wrap-mode countdown from 10 by 3
        drive(1'b0, 1'b1, 8'd10, 8'd3, 1'b0, 1'b0); tick("t2.load");
        drive(1'b1, 1'b0, 8'd0, 8'd3, 1'b0, 1'b0);
        tick("t2.s1"); tick("t2.s2"); tick("t2.s3"); tick("t2.s4");
        check("t2.wrap_d", 32'(bus.d), 32'h0000_00FE);
        check("t2.wrap_bout", 32'(bus.bout), 32'd1);
        drive(1'b0, 1'b0, 8'd0, 8'd3, 1'b0, 1'b0); tick("t2.idle");

        // Exact zero, then saturating borrow into HALT
        drive(1'b0, 1'b1, 8'd5, 8'd5, 1'b0, 1'b0); tick("t3.load");
        drive(1'b1, 1'b0, 8'd0, 8'd5, 1'b0, 1'b0); tick("t3.zero");
        check("t3.zero_flag", 32'(bus.zero), 32'd1);
        drive(1'b1, 1'b0, 8'd0, 8'd1, 1'b1, 1'b0); tick("t3.sat");
        check("t3.halted", 32'(bus.halted), 32'd1);
        tick("t3.hold1"); tick("t3.hold2");

        // clear_halt wins over enable on the same edge
        drive(1'b1, 1'b0, 8'd0, 8'd1, 1'b0, 1'b1); tick("t4.clear");
        check("t4.d_kept", 32'(bus.d), 32'd0);
        drive(1'b1, 1'b0, 8'd0, 8'd1, 1'b0, 1'b0); tick("t4.resume");

        // load wins over enable
        drive(1'b1, 1'b1, 8'd20, 8'd4, 1'b0, 1'b0); tick("t5.load");
        drive(1'b1, 1'b0, 8'd0, 8'd4, 1'b0, 1'b0); tick("t5.sub");
        check("t5.d16", 32'(bus.d), 32'd16);

        // Zero step keeps the value while running, then reset during RUN
        drive(1'b0, 1'b1, 8'h42, 8'd0, 1'b0, 1'b0); tick("t6.load");
        drive(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        tick("t6.s1"); tick("t6.s2"); tick("t6.s3");
        check("t6.busy", 32'(bus.busy), 32'd1);
        do_reset("t6.rst");

        // Randomized traffic; clear_halt is only exercised while halted
        for (int i = 0; i < 600; i++) begin
            logic en, ld, sm, ch;
            logic [7:0] lv, st;
            en = ($urandom_range(0, 3) != 0);
            ld = ($urandom_range(0, 15) == 0);
            sm = $urandom_range(0, 1) == 1;
            ch = (m_st == M_HALT) && ($urandom_range(0, 2) == 0);
            lv = 8'($urandom);
            st = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 8)) : 8'($urandom);
            drive(en, ld, lv, st, sm, ch);
            if ($urandom_range(0, 99) == 0) do_reset("rnd.rst");
            else tick("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
